cache_control: RTL and testbench

- FSM controller that sequences the 2-way set-associative, write-back, write-allocate L1 cache datapath. The datapath has 8 sets, 16-byte lines and 1-bit LRU per set.
- Sits between the CPU memory port (mem_read/mem_write/mem_resp) and physical memory (pmem_*).
- Drives every load, mux-select and bit-input control of the datapath.
- Keeps saturating hit, miss and writeback counters for performance bring-up.

---
 rtl/cache_control_pkg.sv | 47 ++++
 rtl/cache_control_if.sv | 61 ++++++
 rtl/cache_control_sat_counter.sv | 23 ++
 rtl/cache_control.sv | 165 ++++++++++++++++
 tb/tb_cache_control.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_control_pkg.sv
// Shared types for the L1 cache controller: FSM state encoding and the
// per-way bundle of array write controls.
package cache_control_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_WRITEBACK = 2'b01,
    S_ALLOCATE  = 2'b10
  } cache_ctrl_state_t;

  // Everything the controller drives into one way of the datapath.
  typedef struct packed {
    logic load_v;
    logic v_in;
    logic load_d;
    logic d_in;
    logic load_tag;
    logic load_data;
    logic data_mux_sel;
  } way_ctrl_t;

  // Line fill from physical memory: new tag, valid, clean, data from pmem.
  function automatic way_ctrl_t fill_ctrl();
    way_ctrl_t c;
    c              = '0;
    c.load_data    = 1'b1;
    c.data_mux_sel = 1'b1;
    c.load_tag     = 1'b1;
    c.load_v       = 1'b1;
    c.v_in         = 1'b1;
    c.load_d       = 1'b1;
    c.d_in         = 1'b0;
    return c;
  endfunction

  // CPU store on a hit: byte-merged data written back, line becomes dirty.
  function automatic way_ctrl_t write_hit_ctrl();
    way_ctrl_t c;
    c              = '0;
    c.load_data    = 1'b1;
    c.data_mux_sel = 1'b0;
    c.load_d       = 1'b1;
    c.d_in         = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/cache_control_if.sv
// Bundle of CPU handshake, physical-memory handshake and datapath
// status/control wires seen by the cache controller.
interface cache_control_if;
  // CPU side
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  // physical memory side
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;
  // datapath status
  logic hit;
  logic comp0;
  logic comp1;
  logic lru_out;
  logic d_out;
  // datapath bit-array inputs
  logic lru_in;
  logic d0_in;
  logic d1_in;
  logic v0_in;
  logic v1_in;
  // datapath write enables
  logic load_v0;
  logic load_v1;
  logic load_d0;
  logic load_d1;
  logic load_tag0;
  logic load_tag1;
  logic load_data0;
  logic load_data1;
  logic load_lru;
  // datapath mux selects
  logic data0_mux_sel;
  logic data1_mux_sel;
  logic data_mux_sel;
  logic tag_mux_sel;
  logic addr_mux_sel;

  // Controller view
  modport master (
    input  mem_read, mem_write, pmem_resp, hit, comp0, comp1, lru_out, d_out,
    output mem_resp, pmem_read, pmem_write,
    output lru_in, d0_in, d1_in, v0_in, v1_in,
    output load_v0, load_v1, load_d0, load_d1, load_tag0, load_tag1,
    output load_data0, load_data1, load_lru,
    output data0_mux_sel, data1_mux_sel, data_mux_sel, tag_mux_sel, addr_mux_sel
  );

  // Datapath / CPU / memory view
  modport slave (
    output mem_read, mem_write, pmem_resp, hit, comp0, comp1, lru_out, d_out,
    input  mem_resp, pmem_read, pmem_write,
    input  lru_in, d0_in, d1_in, v0_in, v1_in,
    input  load_v0, load_v1, load_d0, load_d1, load_tag0, load_tag1,
    input  load_data0, load_data1, load_lru,
    input  data0_mux_sel, data1_mux_sel, data_mux_sel, tag_mux_sel, addr_mux_sel
  );

endinterface

// File: rtl/cache_control_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [width-1:0] count
);

  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};
  localparam logic [width-1:0] MAX = {width{1'b1}};

  // Count events until the ceiling is reached, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative, write-back, write-allocate L1
// cache. Hits complete in the compare cycle; misses optionally write back
// the dirty victim, fill the line, then re-run the compare which hits.
module cache_control
  import cache_control_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_control_if.master      bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  cache_ctrl_state_t state_reg, state_next;
  logic              victim_reg, victim_next;

  logic              req;
  logic              is_write;
  logic              hit_way;

  way_ctrl_t [1:0]   way_ctrl;
  logic              mem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic              lru_in;
  logic              load_lru;
  logic              data_mux_sel;
  logic              tag_mux_sel;
  logic              addr_mux_sel;
  logic              hit_inc;
  logic              miss_inc;
  logic              wb_inc;

  // A simultaneous read+write request is treated as a write.
  assign req      = bus.mem_read | bus.mem_write;
  assign is_write = bus.mem_write;
  assign hit_way  = bus.comp1;

  // State and victim-way registers; victim is captured once per miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      victim_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      victim_reg <= victim_next;
    end
  end

  // Next-state and control outputs; while reset is asserted everything
  // stays at its default so no array is written.
  always_comb begin
    state_next   = state_reg;
    victim_next  = victim_reg;
    way_ctrl     = '0;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    lru_in       = 1'b0;
    load_lru     = 1'b0;
    data_mux_sel = 1'b0;
    tag_mux_sel  = 1'b0;
    addr_mux_sel = 1'b0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    wb_inc       = 1'b0;

    if (rst_n) begin
      case (state_reg)
        S_IDLE: begin
          if (req) begin
            if (bus.hit) begin
              mem_resp     = 1'b1;
              data_mux_sel = hit_way;
              load_lru     = 1'b1;
              lru_in       = bus.comp0;  // the way not hit becomes LRU
              hit_inc      = 1'b1;
              if (is_write) begin
                way_ctrl[hit_way] = write_hit_ctrl();
              end
            end else begin
              victim_next = bus.lru_out;
              miss_inc    = 1'b1;
              state_next  = bus.d_out ? S_WRITEBACK : S_ALLOCATE;
            end
          end
        end

        S_WRITEBACK: begin
          pmem_write   = 1'b1;
          addr_mux_sel = 1'b1;
          tag_mux_sel  = victim_reg;
          data_mux_sel = victim_reg;
          if (bus.pmem_resp) begin
            wb_inc     = 1'b1;
            state_next = S_ALLOCATE;
          end
        end

        S_ALLOCATE: begin
          pmem_read    = 1'b1;
          addr_mux_sel = 1'b0;
          if (bus.pmem_resp) begin
            way_ctrl[victim_reg] = fill_ctrl();
            state_next           = S_IDLE;
          end
        end

        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_resp      = mem_resp;
  assign bus.pmem_read     = pmem_read;
  assign bus.pmem_write    = pmem_write;
  assign bus.lru_in        = lru_in;
  assign bus.load_lru      = load_lru;
  assign bus.data_mux_sel  = data_mux_sel;
  assign bus.tag_mux_sel   = tag_mux_sel;
  assign bus.addr_mux_sel  = addr_mux_sel;

  assign bus.load_v0       = way_ctrl[0].load_v;
  assign bus.v0_in         = way_ctrl[0].v_in;
  assign bus.load_d0       = way_ctrl[0].load_d;
  assign bus.d0_in         = way_ctrl[0].d_in;
  assign bus.load_tag0     = way_ctrl[0].load_tag;
  assign bus.load_data0    = way_ctrl[0].load_data;
  assign bus.data0_mux_sel = way_ctrl[0].data_mux_sel;

  assign bus.load_v1       = way_ctrl[1].load_v;
  assign bus.v1_in         = way_ctrl[1].v_in;
  assign bus.load_d1       = way_ctrl[1].load_d;
  assign bus.d1_in         = way_ctrl[1].d_in;
  assign bus.load_tag1     = way_ctrl[1].load_tag;
  assign bus.load_data1    = way_ctrl[1].load_data;
  assign bus.data1_mux_sel = way_ctrl[1].data_mux_sel;

  sat_counter #(.width(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.width(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc),
    .count (miss_count)
  );

  sat_counter #(.width(CNT_WIDTH)) u_wb_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wb_inc),
    .count (wb_count)
  );

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: directed vector table, hand-written reset and
// saturation sequences, and randomized requests against a cache model.
module tb_cache_control;

  typedef struct packed {
    logic rd;
    logic wr;
    logic presp;
    logic hit;
    logic comp0;
    logic comp1;
    logic lru_out;
    logic d_out;
  } ins_t;

  typedef struct packed {
    logic mem_resp;
    logic pmem_read;
    logic pmem_write;
    logic lru_in;
    logic d0_in;
    logic d1_in;
    logic v0_in;
    logic v1_in;
    logic load_v0;
    logic load_v1;
    logic load_d0;
    logic load_d1;
    logic load_tag0;
    logic load_tag1;
    logic load_data0;
    logic load_data1;
    logic load_lru;
    logic data0_mux_sel;
    logic data1_mux_sel;
    logic data_mux_sel;
    logic tag_mux_sel;
    logic addr_mux_sel;
  } outs_t;

  typedef struct {
    ins_t        in;
    outs_t       exp;
    logic [15:0] eh;
    logic [15:0] em;
    logic [15:0] ew;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] hit_count, miss_count, wb_count;
  logic [1:0]  hit2, miss2, wb2;

  int vectors = 0;
  int miscompares = 0;

  // reference cache model (8 sets x 2 ways) and expected counter values
  bit          valid_m [8][2];
  bit [1:0]    tag_m   [8][2];
  bit          dirty_m [8][2];
  bit          lru_m   [8];
  logic [15:0] m_hit, m_miss, m_wb;

  vec_t tbl [20];

  always #5 clk = ~clk;

  cache_control_if bus ();
  cache_control_if bus2 ();

  cache_control #(.CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );

  cache_control #(.CNT_WIDTH(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus2),
    .hit_count  (hit2),
    .miss_count (miss2),
    .wb_count   (wb2)
  );

  function automatic ins_t mk_in(bit rd, bit wr, bit presp, bit h, bit c0, bit c1, bit lru, bit d);
    ins_t i;
    i.rd = rd; i.wr = wr; i.presp = presp; i.hit = h;
    i.comp0 = c0; i.comp1 = c1; i.lru_out = lru; i.d_out = d;
    return i;
  endfunction

  // compare cycle that hits way w (store if wr)
  function automatic outs_t exp_hit(bit w, bit wr);
    outs_t o = '0;
    o.mem_resp = 1'b1;
    o.load_lru = 1'b1;
    o.lru_in = ~w;
    o.data_mux_sel = w;
    if (wr) begin
      if (w) begin o.load_data1 = 1'b1; o.load_d1 = 1'b1; o.d1_in = 1'b1; end
      else   begin o.load_data0 = 1'b1; o.load_d0 = 1'b1; o.d0_in = 1'b1; end
    end
    return o;
  endfunction

  function automatic outs_t exp_wb(bit v);
    outs_t o = '0;
    o.pmem_write = 1'b1;
    o.addr_mux_sel = 1'b1;
    o.tag_mux_sel = v;
    o.data_mux_sel = v;
    return o;
  endfunction

  function automatic outs_t exp_alloc(bit v, bit resp);
    outs_t o = '0;
    o.pmem_read = 1'b1;
    if (resp) begin
      if (v) begin
        o.load_data1 = 1'b1; o.data1_mux_sel = 1'b1; o.load_tag1 = 1'b1;
        o.load_v1 = 1'b1; o.v1_in = 1'b1; o.load_d1 = 1'b1;
      end else begin
        o.load_data0 = 1'b1; o.data0_mux_sel = 1'b1; o.load_tag0 = 1'b1;
        o.load_v0 = 1'b1; o.v0_in = 1'b1; o.load_d0 = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic outs_t get_outs();
    outs_t o;
    o.mem_resp = bus.mem_resp;     o.pmem_read = bus.pmem_read;
    o.pmem_write = bus.pmem_write; o.lru_in = bus.lru_in;
    o.d0_in = bus.d0_in;           o.d1_in = bus.d1_in;
    o.v0_in = bus.v0_in;           o.v1_in = bus.v1_in;
    o.load_v0 = bus.load_v0;       o.load_v1 = bus.load_v1;
    o.load_d0 = bus.load_d0;       o.load_d1 = bus.load_d1;
    o.load_tag0 = bus.load_tag0;   o.load_tag1 = bus.load_tag1;
    o.load_data0 = bus.load_data0; o.load_data1 = bus.load_data1;
    o.load_lru = bus.load_lru;
    o.data0_mux_sel = bus.data0_mux_sel; o.data1_mux_sel = bus.data1_mux_sel;
    o.data_mux_sel = bus.data_mux_sel;   o.tag_mux_sel = bus.tag_mux_sel;
    o.addr_mux_sel = bus.addr_mux_sel;
    return o;
  endfunction

  task automatic drive(input ins_t in);
    bus.mem_read = in.rd;   bus.mem_write = in.wr; bus.pmem_resp = in.presp;
    bus.hit = in.hit;       bus.comp0 = in.comp0;  bus.comp1 = in.comp1;
    bus.lru_out = in.lru_out; bus.d_out = in.d_out;
  endtask

  task automatic check_now(input outs_t exp, input logic [15:0] eh, input logic [15:0] em,
                           input logic [15:0] ew, input string name);
    outs_t got;
    got = get_outs();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s outputs: got %h, required %h", name, got, exp);
    end
    vectors++;
    if ({hit_count, miss_count, wb_count} !== {eh, em, ew}) begin
      miscompares++;
      $display("FAIL %s counters: got hit=%0d miss=%0d wb=%0d, required hit=%0d miss=%0d wb=%0d",
               name, hit_count, miss_count, wb_count, eh, em, ew);
    end
  endtask

  // apply inputs after the falling edge, check before the rising edge
  task automatic step(input ins_t in, input outs_t exp, input logic [15:0] eh,
                      input logic [15:0] em, input logic [15:0] ew, input string name);
    @(negedge clk);
    drive(in);
    #3;
    check_now(exp, eh, em, ew, name);
  endtask

  function automatic bit lookup(input logic [2:0] s, input logic [1:0] tg, output bit w);
    bit h0, h1;
    h0 = valid_m[s][0] && (tag_m[s][0] == tg);
    h1 = valid_m[s][1] && (tag_m[s][1] == tg);
    w = h1;
    return h0 | h1;
  endfunction

  function automatic ins_t dp_in(input logic [2:0] s, input logic [1:0] tg, input bit rd,
                                 input bit wr, input bit presp);
    bit h0, h1;
    h0 = valid_m[s][0] && (tag_m[s][0] == tg);
    h1 = valid_m[s][1] && (tag_m[s][1] == tg);
    return mk_in(rd, wr, presp, h0 | h1, h0, h1, lru_m[s], dirty_m[s][lru_m[s]]);
  endfunction

  // one CPU request against the model, with lat pmem wait cycles
  task automatic run_txn(input logic [2:0] s, input logic [1:0] tg, input bit rd, input bit wr,
                         input int lat);
    bit w, v, missed;
    missed = 1'b0;
    if (!lookup(s, tg, w)) begin
      missed = 1'b1;
      v = lru_m[s];
      step(dp_in(s, tg, rd, wr, 1'b0), '0, m_hit, m_miss, m_wb, "rnd_cmp");
      m_miss++;
      if (valid_m[s][v] && dirty_m[s][v]) begin
        for (int i = 0; i < lat; i++)
          step(dp_in(s, tg, rd, wr, 1'b0), exp_wb(v), m_hit, m_miss, m_wb, "rnd_wb");
        step(dp_in(s, tg, rd, wr, 1'b1), exp_wb(v), m_hit, m_miss, m_wb, "rnd_wb_resp");
        m_wb++;
      end
      for (int i = 0; i < lat; i++)
        step(dp_in(s, tg, rd, wr, 1'b0), exp_alloc(v, 1'b0), m_hit, m_miss, m_wb, "rnd_alloc");
      step(dp_in(s, tg, rd, wr, 1'b1), exp_alloc(v, 1'b1), m_hit, m_miss, m_wb, "rnd_fill");
      valid_m[s][v] = 1'b1;
      tag_m[s][v]   = tg;
      dirty_m[s][v] = 1'b0;
      void'(lookup(s, tg, w));
    end
    step(dp_in(s, tg, rd, wr, 1'b0), exp_hit(w, wr), m_hit, m_miss, m_wb, "rnd_hit");
    m_hit++;
    lru_m[s] = ~w;
    if (wr) dirty_m[s][w] = 1'b1;
    $display("txn set=%0d tag=%0d rd=%0b wr=%0b way=%0d miss=%0b", s, tg, rd, wr, w, missed);
  endtask

  initial begin
    ins_t idle;
    idle = '0;
    rst_n = 1'b0;
    drive(idle);
    bus2.mem_read = 0; bus2.mem_write = 0; bus2.pmem_resp = 0; bus2.hit = 0;
    bus2.comp0 = 0; bus2.comp1 = 0; bus2.lru_out = 0; bus2.d_out = 0;

    // directed sequence: cold miss, hits, fill way 1, dirty eviction, both-asserted
    tbl[0]  = '{mk_in(1,0,0,0,0,0,0,0), '0,                 0, 0, 0, "cold_cmp"};
    tbl[1]  = '{mk_in(1,0,0,0,0,0,0,0), exp_alloc(0,0),     0, 1, 0, "cold_alloc"};
    tbl[2]  = '{mk_in(1,0,1,0,0,0,0,0), exp_alloc(0,1),     0, 1, 0, "cold_fill"};
    tbl[3]  = '{mk_in(1,0,0,1,1,0,1,0), exp_hit(0,0),       0, 1, 0, "cold_rehit"};
    tbl[4]  = '{mk_in(0,0,0,0,0,0,1,0), '0,                 1, 1, 0, "idle0"};
    tbl[5]  = '{mk_in(1,0,0,1,1,0,0,0), exp_hit(0,0),       1, 1, 0, "rd_hit"};
    tbl[6]  = '{mk_in(0,1,0,1,1,0,1,0), exp_hit(0,1),       2, 1, 0, "wr_hit0"};
    tbl[7]  = '{mk_in(1,0,0,0,0,0,1,0), '0,                 3, 1, 0, "w1_cmp"};
    tbl[8]  = '{mk_in(1,0,0,0,0,0,1,0), exp_alloc(1,0),     3, 2, 0, "w1_alloc"};
    tbl[9]  = '{mk_in(1,0,1,0,0,0,1,0), exp_alloc(1,1),     3, 2, 0, "w1_fill"};
    tbl[10] = '{mk_in(1,0,0,1,0,1,1,0), exp_hit(1,0),       3, 2, 0, "w1_rehit"};
    tbl[11] = '{mk_in(0,1,0,0,0,0,0,1), '0,                 4, 2, 0, "ev_cmp"};
    tbl[12] = '{mk_in(0,1,0,0,0,0,1,0), exp_wb(0),          4, 3, 0, "ev_wb"};
    tbl[13] = '{mk_in(0,1,1,0,0,0,1,0), exp_wb(0),          4, 3, 0, "ev_wb_resp"};
    tbl[14] = '{mk_in(0,1,0,0,0,0,1,0), exp_alloc(0,0),     4, 3, 1, "ev_alloc"};
    tbl[15] = '{mk_in(0,1,1,0,0,0,1,0), exp_alloc(0,1),     4, 3, 1, "ev_fill"};
    tbl[16] = '{mk_in(0,1,0,1,1,0,1,0), exp_hit(0,1),       4, 3, 1, "ev_rehit"};
    tbl[17] = '{mk_in(1,1,0,1,0,1,0,0), exp_hit(1,1),       5, 3, 1, "both_is_wr"};
    tbl[18] = '{mk_in(0,0,1,0,0,0,0,0), '0,                 6, 3, 1, "idle_presp"};
    tbl[19] = '{mk_in(0,0,0,0,0,0,0,0), '0,                 6, 3, 1, "idle_end"};

    // reset state, even with a hitting request presented
    #3;
    check_now('0, 0, 0, 0, "reset_idle");
    drive(mk_in(1,1,0,1,1,0,0,0));
    #1;
    check_now('0, 0, 0, 0, "reset_req");
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i].in, tbl[i].exp, tbl[i].eh, tbl[i].em, tbl[i].ew, tbl[i].name);

    // reset asserted in the middle of a writeback
    step(mk_in(0,1,0,0,0,0,1,1), '0,        6, 3, 1, "mwb_cmp");
    step(mk_in(0,1,0,0,0,0,0,1), exp_wb(1), 6, 4, 1, "mwb_wb");
    @(negedge clk);
    drive(mk_in(0,1,0,0,0,0,0,1));
    #1;
    check_now(exp_wb(1), 6, 4, 1, "mwb_pre");
    rst_n = 1'b0;
    #1;
    check_now('0, 0, 0, 0, "mwb_rst");
    @(negedge clk);
    drive(mk_in(0,1,1,0,0,0,0,1));
    #3;
    check_now('0, 0, 0, 0, "mwb_hold");
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;
    #3;
    check_now('0, 0, 0, 0, "mwb_release");
    step(mk_in(1,0,0,1,1,0,0,0), exp_hit(0,0), 0, 0, 0, "mwb_idle_hit");
    step(idle, '0, 1, 0, 0, "mwb_after");

    // randomized requests against the model from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    for (int s = 0; s < 8; s++) begin
      lru_m[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        valid_m[s][w] = 1'b0; tag_m[s][w] = 2'd0; dirty_m[s][w] = 1'b0;
      end
    end
    m_hit = '0; m_miss = '0; m_wb = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 150; t++) begin
      logic [2:0] s;
      logic [1:0] tg;
      int kind;
      s    = 3'($urandom_range(0, 7));
      tg   = 2'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 3));
      run_txn(s, tg, kind != 1, (kind == 1) || (kind == 2), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) step(idle, '0, m_hit, m_miss, m_wb, "rnd_idle");
    end
    step(idle, '0, m_hit, m_miss, m_wb, "rnd_final");

    // saturation on the 2-bit instance: five hits, count stops at 3
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus2.mem_read = 1'b1; bus2.hit = 1'b1; bus2.comp0 = 1'b1;
      #3;
      vectors++;
      if ({bus2.mem_resp, hit2} !== {1'b1, 2'((i > 3) ? 3 : i)}) begin
        miscompares++;
        $display("FAIL sat_hit%0d: got resp=%0b hit=%0d, required resp=1 hit=%0d",
                 i, bus2.mem_resp, hit2, (i > 3) ? 3 : i);
      end
    end
    @(negedge clk);
    bus2.mem_read = 1'b0; bus2.hit = 1'b0; bus2.comp0 = 1'b0;
    #3;
    vectors++;
    if ({hit2, miss2, wb2} !== {2'd3, 2'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL sat_final: got hit=%0d miss=%0d wb=%0d, required hit=3 miss=0 wb=0",
               hit2, miss2, wb2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
